float_div: RTL and testbench

FLOAT_DIV -- requirements
Module: float_div

---
 rtl/float_div.sv | 138 +++++++++++++
 tb/tb_float_div.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/float_div.sv
// Iterative 13-bit floating-point divider: restoring division of the significands,
// one quotient bit per cycle, followed by a single normalise/classify step.
module float_div #(
  parameter int EXP_BIAS = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [12:0] a,
  input  logic [12:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [12:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero
);

  localparam logic signed [7:0] BIAS8     = 8'(EXP_BIAS);
  localparam logic        [3:0] ITER_LOAD = 4'd10;

  typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic [4:0]  r_aHi;
  logic [12:0] r_b;
  logic [10:0] r_rem;
  logic [9:0]  r_quot;
  logic [3:0]  r_count;

  logic        w_accept;
  logic [8:0]  w_sb;
  logic        w_qBit;
  logic [10:0] w_trial;
  logic [10:0] w_remKeep;

  logic        w_aZero;
  logic        w_bZero;
  logic        w_sign;
  logic signed [7:0] w_expBase;
  logic signed [7:0] w_expNorm;
  logic [7:0]  w_frac;
  logic [12:0] w_normResult;
  logic        w_normOv;
  logic        w_normUn;
  logic        w_normDz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_nextState = CALC;
      CALC:    if (r_count == 4'd1) w_nextState = NORM;
      NORM:    w_nextState = DONE;
      DONE:    if (out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  assign w_accept = in_valid && in_ready;

  // Restoring step: subtract the divisor significand when it fits, then shift.
  assign w_sb      = {1'b1, r_b[7:0]};
  assign w_qBit    = (r_rem >= {2'b00, w_sb});
  assign w_trial   = r_rem - {2'b00, w_sb};
  assign w_remKeep = w_qBit ? w_trial : r_rem;

  assign w_aZero   = (r_aHi[3:0] == 4'd0);
  assign w_bZero   = (r_b[11:8] == 4'd0);
  assign w_sign    = r_aHi[4] ^ r_b[12];
  assign w_expBase = $signed({4'b0000, r_aHi[3:0]}) - $signed({4'b0000, r_b[11:8]}) + BIAS8;
  assign w_expNorm = r_quot[9] ? w_expBase : (w_expBase - 8'sd1);
  assign w_frac    = r_quot[9] ? r_quot[8:1] : r_quot[7:0];

  // Divide-by-zero wins over a zero dividend, which wins over range checks.
  always_comb begin
    w_normResult = 13'h0000;
    w_normOv     = 1'b0;
    w_normUn     = 1'b0;
    w_normDz     = 1'b0;
    if (w_bZero) begin
      w_normResult = {w_sign, 4'hF, 8'hFF};
      w_normDz     = 1'b1;
    end else if (w_aZero) begin
      w_normResult = 13'h0000;
    end else if (w_expNorm > 8'sd15) begin
      w_normResult = {w_sign, 4'hF, 8'hFF};
      w_normOv     = 1'b1;
    end else if (w_expNorm < 8'sd1) begin
      w_normResult = 13'h0000;
      w_normUn     = 1'b1;
    end else begin
      w_normResult = {w_sign, w_expNorm[3:0], w_frac};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aHi       <= 5'd0;
      r_b         <= 13'h0000;
      r_rem       <= 11'd0;
      r_quot      <= 10'd0;
      r_count     <= 4'd0;
      result      <= 13'h0000;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (w_accept) begin
      r_aHi   <= a[12:8];
      r_b     <= b;
      r_rem   <= {2'b00, 1'b1, a[7:0]};
      r_quot  <= 10'd0;
      r_count <= ITER_LOAD;
    end else if (r_state == CALC) begin
      r_quot  <= {r_quot[8:0], w_qBit};
      r_rem   <= {w_remKeep[9:0], 1'b0};
      r_count <= r_count - 4'd1;
    end else if (r_state == NORM) begin
      result      <= w_normResult;
      overflow    <= w_normOv;
      underflow   <= w_normUn;
      div_by_zero <= w_normDz;
    end
  end

endmodule

// File: tb/tb_float_div.sv
// Directed self-checking bench for float_div: latency, arithmetic cases,
// special operands, output back-pressure and mid-operation reset.
module tb_float_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] a;
  logic [12:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] result;
  logic        overflow;
  logic        underflow;
  logic        div_by_zero;

  int checkCount = 0;
  int errorCount = 0;

  float_div #(.EXP_BIAS(7)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .underflow(underflow),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one operand pair, then counts edges until out_valid (bounded).
  task automatic applyStimulus(input logic [12:0] aa, input logic [12:0] bb, output int lat);
    @(negedge clk);
    a = aa;
    b = bb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic runOp(input string tag, input logic [12:0] aa, input logic [12:0] bb,
                       input logic [12:0] expRes, input logic [2:0] expFlags);
    int lat;
    applyStimulus(aa, bb, lat);
    checkOutput({tag, " latency"}, 13'(lat), 13'd11);
    checkOutput({tag, " result"}, result, expRes);
    checkOutput({tag, " flags"}, {10'd0, overflow, underflow, div_by_zero}, {10'd0, expFlags});
    @(posedge clk);
    #1;
    checkOutput({tag, " in_ready after"}, {12'd0, in_ready}, 13'd1);
  endtask

  initial begin
    int lat;
    int seen;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = 13'h0000;
    b = 13'h0000;
    #12;
    checkOutput("reset out_valid", {12'd0, out_valid}, 13'd0);
    checkOutput("reset result", result, 13'h0000);
    checkOutput("reset flags", {10'd0, overflow, underflow, div_by_zero}, 13'd0);
    checkOutput("reset in_ready", {12'd0, in_ready}, 13'd1);
    @(negedge clk);
    rst = 1'b0;

    runOp("1/2",      13'h0700, 13'h0800, 13'h0600, 3'b000);
    runOp("1/1.5",    13'h0700, 13'h0780, 13'h0655, 3'b000);
    runOp("3/1.5",    13'h0880, 13'h0780, 13'h0800, 3'b000);
    runOp("-1/2",     13'h1700, 13'h0800, 13'h1600, 3'b000);
    runOp("ovf",      13'h0F00, 13'h0100, 13'h0FFF, 3'b100);
    runOp("unf",      13'h0100, 13'h0F00, 13'h0000, 3'b010);
    runOp("neg unf",  13'h1100, 13'h0F00, 13'h0000, 3'b010);
    runOp("x/0",      13'h0700, 13'h0000, 13'h0FFF, 3'b001);
    runOp("-x/0",     13'h1700, 13'h0000, 13'h1FFF, 3'b001);
    runOp("0/0",      13'h0000, 13'h0055, 13'h0FFF, 3'b001);
    runOp("0/x",      13'h0000, 13'h0700, 13'h0000, 3'b000);
    runOp("-0/x",     13'h1033, 13'h0700, 13'h0000, 3'b000);

    // Back-pressure: result must hold while stray in_valid pulses arrive.
    out_ready = 1'b0;
    applyStimulus(13'h0700, 13'h0780, lat);
    checkOutput("hold latency", 13'(lat), 13'd11);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 13'h0F00;
      b = 13'h0100;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("hold result", result, 13'h0655);
      checkOutput("hold flags", {10'd0, overflow, underflow, div_by_zero}, 13'd0);
      checkOutput("hold in_ready", {12'd0, in_ready}, 13'd0);
      checkOutput("hold out_valid", {12'd0, out_valid}, 13'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("release in_ready", {12'd0, in_ready}, 13'd1);
    checkOutput("release out_valid", {12'd0, out_valid}, 13'd0);

    // Reset in the middle of an operation.
    @(negedge clk);
    a = 13'h0700;
    b = 13'h0800;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    checkOutput("abort out_valid", {12'd0, out_valid}, 13'd0);
    checkOutput("abort result", result, 13'h0000);
    checkOutput("abort in_ready", {12'd0, in_ready}, 13'd1);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen++;
    end
    checkOutput("abort no out_valid", 13'(seen), 13'd0);
    checkOutput("abort idle in_ready", {12'd0, in_ready}, 13'd1);
    runOp("after abort", 13'h0700, 13'h0800, 13'h0600, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
